// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding, word-length codes, default
// oversampling ratio, the received-character record and parity helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_e;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } rx_char_t;

  // Index of the last data bit for a word-length code (4..7).
  function automatic logic [2:0] last_bit_idx(input wls_e wls);
    return 3'd4 + {1'b0, wls};
  endfunction

  // Parity bit the transmitter should have sent for this character.
  function automatic logic parity_expected(input logic [7:0] data,
                                           input logic       eps,
                                           input logic       sp);
    logic p_s;
    if (sp) begin
      p_s = ~eps;
    end else if (eps) begin
      p_s = ^data;
    end else begin
      p_s = ~(^data);
    end
    return p_s;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Character handshake between the UART receiver and its RX FIFO.
interface uart_rx_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       pe_o;
  logic       fe_o;
  logic       bi_o;

  modport master (
    output rx_data_o, rx_valid_o, pe_o, fe_o, bi_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o, rx_valid_o, pe_o, fe_o, bi_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs (RX, CTS, DSR).
// RESET_VAL lets idle-high and idle-low lines come out of reset inactive.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_r;
  logic sync_r;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling, parity,
// framing and break checks, and a one-entry holding register toward the FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       baud_tick_i,
  input  logic       rx_i,
  input  logic [1:0] wls_i,
  input  logic       pen_i,
  input  logic       eps_i,
  input  logic       sp_i,
  uart_rx_if.master  rx_bus,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam logic [3:0] SAMPLE_PT = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] CNT_MAX   = 4'(OVERSAMPLE - 1);

  logic       rx_s;
  logic       rx_prev_r;
  rx_state_e  state_r;
  rx_state_e  state_s;
  logic [3:0] tick_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] data_r;
  logic       any_one_r;
  logic       pe_calc_r;
  wls_e       wls_r;
  logic       pen_r;
  logic       eps_r;
  logic       sp_r;
  rx_char_t   hold_r;
  rx_char_t   new_char_s;
  logic       valid_r;
  logic       overrun_r;
  logic       busy_r;

  logic       sample_s;
  logic       last_bit_s;
  logic       brk_s;
  logic       start_det_s;
  logic       shift_en_s;
  logic       par_en_s;
  logic       cpl_s;

  uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  assign sample_s   = baud_tick_i && (tick_cnt_r == SAMPLE_PT);
  assign last_bit_s = (bit_cnt_r == last_bit_idx(wls_r));
  assign brk_s      = ~rx_s & ~any_one_r;

  // Previous synchronized line level for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_prev_r <= 1'b1;
    end else begin
      rx_prev_r <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_det_s) state_s = ST_START;
        else             state_s = state_r;
      end
      ST_START: begin
        if (sample_s) state_s = rx_s ? ST_IDLE : ST_DATA;
        else          state_s = state_r;
      end
      ST_DATA: begin
        if (sample_s && last_bit_s) state_s = pen_r ? ST_PARITY : ST_STOP;
        else                        state_s = state_r;
      end
      ST_PARITY: begin
        if (sample_s) state_s = ST_STOP;
        else          state_s = state_r;
      end
      ST_STOP: begin
        if (sample_s) state_s = brk_s ? ST_BRK_WAIT : ST_IDLE;
        else          state_s = state_r;
      end
      ST_BRK_WAIT: begin
        if (rx_s) state_s = ST_IDLE;
        else      state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM datapath controls decoded from the current state.
  always_comb begin
    start_det_s = 1'b0;
    shift_en_s  = 1'b0;
    par_en_s    = 1'b0;
    cpl_s       = 1'b0;
    case (state_r)
      ST_IDLE:   start_det_s = rx_prev_r & ~rx_s;
      ST_DATA:   shift_en_s  = sample_s;
      ST_PARITY: par_en_s    = sample_s;
      ST_STOP:   cpl_s       = sample_s;
      default: begin
        start_det_s = 1'b0;
      end
    endcase
  end

  // Oversampling counter, phase-aligned to the detected start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_r <= 4'd0;
    end else if (start_det_s) begin
      tick_cnt_r <= 4'd0;
    end else if (baud_tick_i && (state_r != ST_IDLE)) begin
      tick_cnt_r <= (tick_cnt_r == CNT_MAX) ? 4'd0 : tick_cnt_r + 4'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Frame configuration latch, data shifter and parity/break bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wls_r     <= WLS_5;
      pen_r     <= 1'b0;
      eps_r     <= 1'b0;
      sp_r      <= 1'b0;
      bit_cnt_r <= 3'd0;
      data_r    <= 8'h00;
      any_one_r <= 1'b0;
      pe_calc_r <= 1'b0;
    end else if (start_det_s) begin
      wls_r     <= wls_e'(wls_i);
      pen_r     <= pen_i;
      eps_r     <= eps_i;
      sp_r      <= sp_i;
      bit_cnt_r <= 3'd0;
      data_r    <= 8'h00;
      any_one_r <= 1'b0;
      pe_calc_r <= 1'b0;
    end else if (shift_en_s) begin
      data_r[bit_cnt_r] <= rx_s;
      bit_cnt_r         <= bit_cnt_r + 3'd1;
      any_one_r         <= any_one_r | rx_s;
    end else if (par_en_s) begin
      pe_calc_r <= rx_s ^ parity_expected(data_r, eps_r, sp_r);
      any_one_r <= any_one_r | rx_s;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Character assembled at the stop-bit sample; a break reports a zero byte.
  always_comb begin
    new_char_s = '0;
    if (brk_s) begin
      new_char_s.data = 8'h00;
      new_char_s.pe   = 1'b0;
      new_char_s.fe   = 1'b1;
      new_char_s.bi   = 1'b1;
    end else begin
      new_char_s.data = data_r;
      new_char_s.pe   = pe_calc_r;
      new_char_s.fe   = ~rx_s;
      new_char_s.bi   = 1'b0;
    end
  end

  // Holding register: load on completion unless full and not draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_r    <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (cpl_s) begin
      if (!valid_r || rx_bus.rx_ready_i) begin
        hold_r    <= new_char_s;
        valid_r   <= 1'b1;
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= 1'b1;
      end
    end else begin
      overrun_r <= 1'b0;
      if (valid_r && rx_bus.rx_ready_i) valid_r <= 1'b0;
      else                              valid_r <= valid_r;
    end
  end

  // Busy flag tracks the state the FSM is entering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
    end
  end

  assign rx_bus.rx_data_o  = hold_r.data;
  assign rx_bus.pe_o       = hold_r.pe;
  assign rx_bus.fe_o       = hold_r.fe;
  assign rx_bus.bi_o       = hold_r.bi;
  assign rx_bus.rx_valid_o = valid_r;
  assign overrun_o         = overrun_r;
  assign busy_o            = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serial frames built from ticks, a queue of expected
// characters derived from the frame rules, and an independent FIFO-side monitor.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         fe;
    bit         bi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_line = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;
  logic       overrun;
  logic       busy;
  logic       rx_ready = 1'b0;
  bit         rand_ready = 1'b1;
  bit         force_ready = 1'b0;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ovr_seen = 0;
  int   ovr_exp = 0;

  uart_rx_if rx_bus();
  assign rx_bus.rx_ready_i = rx_ready;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .baud_tick_i (baud_tick),
    .rx_i        (rx_line),
    .wls_i       (wls),
    .pen_i       (pen),
    .eps_i       (eps),
    .sp_i        (sp),
    .rx_bus      (rx_bus),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock in four.
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      baud_tick = (div == 0);
    end
  end

  // FIFO ready: random or directed.
  initial begin
    forever begin
      @(negedge clk);
      rx_ready = rand_ready ? ($urandom_range(0, 1) == 1) : force_ready;
    end
  end

  // Monitor: compare every accepted character and count overrun pulses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rx_bus.rx_valid_o === 1'b1 && rx_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_char: got data=%02h pe=%0b fe=%0b bi=%0b, none expected",
                   rx_bus.rx_data_o, rx_bus.pe_o, rx_bus.fe_o, rx_bus.bi_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rx_bus.rx_data_o !== e.data || rx_bus.pe_o !== e.pe ||
              rx_bus.fe_o !== e.fe || rx_bus.bi_o !== e.bi) begin
            errors++;
            $display("FAIL char: got data=%02h pe=%0b fe=%0b bi=%0b, expected data=%02h pe=%0b fe=%0b bi=%0b",
                     rx_bus.rx_data_o, rx_bus.pe_o, rx_bus.fe_o, rx_bus.bi_o,
                     e.data, e.pe, e.fe, e.bi);
          end
        end
      end
      if (overrun === 1'b1) ovr_seen++;
    end
  end

  // Global time bound.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit good_parity(input logic [7:0] d, input bit e, input bit s);
    int ones;
    ones = $countones(d);
    if (s) return !e;
    return e ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  // Expected character from the frame as sent on the wire.
  function automatic exp_t model(input logic [7:0] b, input int nbits, input bit p,
                                 input bit e, input bit s, input bit par_bit, input bit stop_v);
    exp_t       r;
    logic [7:0] d;
    d = b & 8'((1 << nbits) - 1);
    if (d == 8'h00 && (!p || !par_bit) && !stop_v) begin
      r.data = 8'h00; r.pe = 1'b0; r.fe = 1'b1; r.bi = 1'b1;
    end else begin
      r.data = d;
      r.pe   = p && (par_bit != good_parity(d, e, s));
      r.fe   = !stop_v;
      r.bi   = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_tick_edge();
    do @(posedge clk); while (baud_tick !== 1'b1);
  endtask

  task automatic hold_line(input logic v, input int ticks);
    rx_line = v;
    repeat (ticks) wait_tick_edge();
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] w, input bit p, input bit e,
                            input bit s, input bit bad_par, input bit stop_v, input int gap,
                            input bit push);
    int         nbits;
    bit         par_bit;
    logic [7:0] d;
    nbits   = 5 + int'(w);
    d       = b & 8'((1 << nbits) - 1);
    par_bit = good_parity(d, e, s) ^ bad_par;
    wls = w; pen = p; eps = e; sp = s;
    if (push) exp_q.push_back(model(b, nbits, p, e, s, par_bit, stop_v));
    wait_tick_edge();
    @(negedge clk);
    hold_line(1'b0, 16);
    wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
    for (int i = 0; i < nbits; i++) hold_line(b[i], 16);
    if (p) hold_line(par_bit, 16);
    hold_line(stop_v, 16);
    hold_line(1'b1, gap);
  endtask

  // Returns at the posedge just before the k-th tick after the start edge.
  task automatic frame_edge(input int k);
    @(negedge rx_line);
    repeat (k - 1) wait_tick_edge();
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset state.
    repeat (5) @(negedge clk);
    #1;
    check("rst_valid", rx_bus.rx_valid_o, 0);
    check("rst_data", rx_bus.rx_data_o, 0);
    check("rst_flags", {rx_bus.pe_o, rx_bus.fe_o, rx_bus.bi_o}, 0);
    check("rst_overrun_busy", {overrun, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("post_rst_busy", busy, 0);

    // 8N1 0xA5 with valid exactly one cycle after the stop sample.
    fork
      send_frame(8'hA5, 2'b11, 0, 0, 0, 0, 1, 20, 1);
      begin
        frame_edge(152);
        @(negedge clk); #1;
        check("valid_before_stop_sample", rx_bus.rx_valid_o, 0);
        @(posedge clk);
        @(negedge clk); #1;
        check("valid_after_stop_sample", rx_bus.rx_valid_o, 1);
        check("data_after_stop_sample", rx_bus.rx_data_o, 32'hA5);
        check("busy_after_stop_sample", busy, 0);
      end
    join
    wait_drain("drain_8n1");

    // 7E1 with a wrong parity bit.
    send_frame(8'h35, 2'b10, 1, 1, 0, 1, 1, 20, 1);
    wait_drain("drain_7e1");

    // Framing error, then a two-frame break.
    send_frame(8'h3C, 2'b11, 0, 0, 0, 0, 0, 20, 1);
    exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    wait_tick_edge();
    @(negedge clk);
    hold_line(1'b0, 320);
    #1;
    check("break_wait_busy", busy, 1);
    wait_drain("drain_break");
    hold_line(1'b1, 20);
    #1;
    check("break_release_busy", busy, 0);

    // Short glitch on the idle line is a false start.
    wait_tick_edge();
    @(negedge clk);
    hold_line(1'b0, 5);
    #1;
    check("glitch_busy_high", busy, 1);
    hold_line(1'b1, 20);
    #1;
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", rx_bus.rx_valid_o, 0);

    // Overrun while the FIFO is not ready.
    rand_ready = 1'b0; force_ready = 1'b0;
    @(negedge clk);
    begin
      int ovr_before;
      ovr_before = ovr_seen;
      send_frame(8'h11, 2'b11, 0, 0, 0, 0, 1, 10, 1);
      send_frame(8'h22, 2'b11, 0, 0, 0, 0, 1, 10, 0);
      ovr_exp++;
      #1;
      check("overrun_hold_valid", rx_bus.rx_valid_o, 1);
      check("overrun_hold_data", rx_bus.rx_data_o, 32'h11);
      check("overrun_pulses", ovr_seen - ovr_before, 1);
    end
    rand_ready = 1'b1;
    wait_drain("drain_overrun");

    // Completion coinciding with the handshake loads without overrun.
    rand_ready = 1'b0; force_ready = 1'b0;
    @(negedge clk);
    begin
      int ovr_before;
      ovr_before = ovr_seen;
      send_frame(8'h33, 2'b11, 0, 0, 0, 0, 1, 10, 1);
      fork
        send_frame(8'h44, 2'b11, 0, 0, 0, 0, 1, 10, 1);
        begin
          frame_edge(152);
          #1 force_ready = 1'b1;
          @(posedge clk);
          #1 force_ready = 1'b0;
        end
      join
      #1;
      check("coincide_valid", rx_bus.rx_valid_o, 1);
      check("coincide_data", rx_bus.rx_data_o, 32'h44);
      check("coincide_no_overrun", ovr_seen - ovr_before, 0);
    end
    rand_ready = 1'b1;
    wait_drain("drain_coincide");

    // Reset in the middle of a frame, then a clean frame.
    fork
      send_frame(8'hC3, 2'b11, 0, 0, 0, 0, 1, 10, 0);
      begin
        @(negedge rx_line);
        repeat (70) wait_tick_edge();
        #2 rst_n = 1'b0;
        @(negedge clk); #1;
        check("midrst_valid", rx_bus.rx_valid_o, 0);
        check("midrst_data", rx_bus.rx_data_o, 0);
        check("midrst_flags", {rx_bus.pe_o, rx_bus.fe_o, rx_bus.bi_o}, 0);
        check("midrst_overrun_busy", {overrun, busy}, 0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h5A, 2'b11, 0, 0, 0, 0, 1, 20, 1);
    wait_drain("drain_after_reset");

    // Randomized frames with random configuration and occasional errors.
    for (int n = 0; n < 12; n++) begin
      logic [1:0] w;
      bit         p, e, s, bp, st;
      w  = 2'($urandom_range(0, 3));
      p  = 1'($urandom);
      e  = 1'($urandom);
      s  = 1'($urandom);
      bp = p && ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 5) != 0);
      send_frame(8'($urandom), w, p, e, s, bp, st, $urandom_range(4, 30), 1);
    end
    wait_drain("drain_random");

    repeat (20) @(negedge clk);
    check("overrun_total", ovr_seen, ovr_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
